// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the CIC decimator and its comb stages.
package cic_pkg;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_STAGES    = 3;
    localparam int DEF_DECIM     = 16;
    localparam int DEF_DIFF_DLY  = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Bit growth of an N-stage CIC is N*log2(R*M) on top of the input width.
    function automatic int acc_width(input int in_width, input int stages,
                                     input int decim, input int diff_dly);
        return in_width + stages * clog2(decim * diff_dly);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: y <= x - x delayed by DIFF_DLY decimated samples,
// advancing only on in_valid; the valid bit is forwarded one cycle later.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int ACC_W    = 28,
    parameter int DIFF_DLY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [ACC_W-1:0] x,
    output logic [ACC_W-1:0] y,
    output logic             out_valid
);

    logic [ACC_W-1:0] y_q, y_d;
    logic [ACC_W-1:0] dly_q [DIFF_DLY];
    logic [ACC_W-1:0] dly_d [DIFF_DLY];
    logic             v_q, v_d;

    always_comb begin
        y_d   = y_q;
        dly_d = dly_q;
        v_d   = in_valid;
        if (in_valid) begin
            y_d      = x - dly_q[DIFF_DLY-1];
            dly_d[0] = x;
            for (int i = 1; i < DIFF_DLY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            y_q <= '0;
            v_q <= 1'b0;
            for (int i = 0; i < DIFF_DLY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            y_q   <= y_d;
            v_q   <= v_d;
            dly_q <= dly_d;
        end
    end

    assign y         = y_q;
    assign out_valid = v_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at input rate, decimate by R, comb chain at
// output rate, MSB-truncated output with a one-cycle valid pulse.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int STAGES    = DEF_STAGES,
    parameter int DECIM     = DEF_DECIM,
    parameter int DIFF_DLY  = DEF_DIFF_DLY,
    localparam int ACC_W    = acc_width(IN_WIDTH, STAGES, DECIM, DIFF_DLY),
    localparam int CNT_W    = clog2(DECIM)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 data_in_valid,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    output logic [CNT_W-1:0]     dec_count
);

    logic [ACC_W-1:0] integ_q [STAGES];
    logic [ACC_W-1:0] integ_d [STAGES];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] dec_q, dec_d;
    logic             v0_q, v0_d;
    logic             acc_en;

    // Integrators wrap modulo 2^ACC_W by design; the combs undo the wrap exactly.
    always_comb begin
        integ_d = integ_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        v0_d    = 1'b0;
        acc_en  = enable & data_in_valid;
        if (acc_en) begin
            integ_d[0] = integ_q[0] + {{(ACC_W-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
            for (int k = 1; k < STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            if (cnt_q == CNT_W'(DECIM - 1)) begin
                cnt_d = '0;
                dec_d = integ_q[STAGES-1];
                v0_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            dec_q <= '0;
            v0_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            v0_q    <= v0_d;
            integ_q <= integ_d;
        end
    end

    logic [ACC_W-1:0] comb_x [STAGES+1];
    logic [STAGES:0]  comb_v;

    assign comb_x[0] = dec_q;
    assign comb_v[0] = v0_q;

    // Comb chain runs regardless of enable so an in-flight sample always drains.
    for (genvar j = 0; j < STAGES; j++) begin : g_comb
        cic_comb_stage #(
            .ACC_W    (ACC_W),
            .DIFF_DLY (DIFF_DLY)
        ) u_comb (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (comb_v[j]),
            .x         (comb_x[j]),
            .y         (comb_x[j+1]),
            .out_valid (comb_v[j+1])
        );
    end

    assign data_out       = comb_x[STAGES][ACC_W-1 -: OUT_WIDTH];
    assign data_out_valid = comb_v[STAGES];
    assign dec_count      = cnt_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator at defaults (N=3, R=16, M=1): driver pushes
// expected pulses into a queue, a negedge monitor pops and compares them.
module tb_cic_decimator;

    localparam int R   = 16;
    localparam int LAT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [3:0]  dec_count;

    cic_decimator #(
        .IN_WIDTH  (16),
        .OUT_WIDTH (16),
        .STAGES    (3),
        .DECIM     (16),
        .DIFF_DLY  (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .dec_count      (dec_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // entry = {check_value, expected_value[15:0], expected_cycle[31:0]}
    logic [48:0] exp_q[$];
    logic [48:0] mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          phase = 0;
    int          n_out = 0;
    logic [15:0] dc_level = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One input cycle; the bench's own phase model predicts when a pulse is due.
    task automatic drive(input logic en, input logic vld, input logic [15:0] d);
        @(posedge clock);
        #1;
        enable        = en;
        data_in_valid = vld;
        data_in       = d;
        if (en && vld && !reset) begin
            if (phase == R - 1) begin
                exp_q.push_back({(n_out >= 3), dc_level, 32'(cyc + LAT)});
                n_out++;
                phase = 0;
            end else begin
                phase++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset(input int n);
        exp_q.delete();
        phase = 0;
        n_out = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            reset         = 1'b1;
            enable        = 1'b1;
            data_in_valid = 1'b1;
            data_in       = 16'h1234;
            if (i > 0) begin
                @(negedge clock);
                check("rst_data_out", data_out, 0);
                check("rst_valid", data_out_valid, 0);
                check("rst_dec_count", dec_count, 0);
            end
        end
        @(posedge clock);
        #1;
        reset         = 1'b0;
        data_in_valid = 1'b0;
        @(negedge clock);
        check("post_rst_data_out", data_out, 0);
        check("post_rst_valid", data_out_valid, 0);
        check("post_rst_dec_count", dec_count, 0);
    endtask

    always @(negedge clock) begin
        if (data_out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", cyc, mon_e[31:0]);
                if (mon_e[48]) check("data_out", data_out, mon_e[47:32]);
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
            check("missing_pulse", 0, 1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        do_reset(5);

        // Count, DC gain and integrator wrap with +1000.
        dc_level = 16'd1000;
        for (int i = 0; i < 960; i++) drive(1'b1, 1'b1, 16'd1000);

        // Gate mid-period at phase 7, then 9 more inputs complete the period.
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 16'd1000);
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b1, 16'd1000);
            @(negedge clock);
            check("gated_dec_count", dec_count, 7);
        end
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 16'd1000);
        idle(LAT + 4);

        // Full-scale negative DC.
        do_reset(2);
        dc_level = 16'h8000;
        for (int i = 0; i < 800; i++) drive(1'b1, 1'b1, 16'h8000);
        idle(LAT + 4);

        // Sparse valid, one sample every third cycle.
        do_reset(2);
        dc_level = 16'd500;
        for (int i = 0; i < 48 * 8; i++) drive(1'b1, (i % 3) == 0, 16'd500);
        idle(LAT + 4);

        // Reset two cycles after a strobe kills the in-flight sample.
        do_reset(2);
        dc_level = 16'd500;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 16'd500);
        drive(1'b1, 1'b1, 16'd500);
        do_reset(2);
        dc_level = 16'd500;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 16'd500);
        idle(LAT + 4);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
